// File: rtl/cpu_pkg.sv
// Shared constants and types for the Antares pipeline front end.
package cpu_pkg;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic               req;
    logic [31:0]        addr;
    logic               ready;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load; an idle cycle yields a bubble.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP = NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bubble_i,
    input  logic               hold_i,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [31:0]        pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc_plus4_o,
    output logic               valid_o
);
    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        pc_q;
    logic [31:0]        pc_plus4_q;
    logic               valid_q;

    always_ff @(posedge clk) begin
        // Nothing to hand over and no stall means decode must not see the old word again.
        if (reset || bubble_i || (!hold_i && !load_i)) begin
            instr_q    <= NOP;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (!hold_i) begin
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_plus4_q <= pc_i + 32'd4;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem request FSM and hand-off into the IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0]        RESET_PC = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP      = NOP_INSTR
) (
    input  logic               Clock,
    input  logic               reset,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [INSTR_W-1:0] instruction_1,
    output logic [31:0]        pc_1,
    output logic [31:0]        pcPlus4_1,
    output logic               valid_1
);
    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        target_q, target_d;
    logic [INSTR_W-1:0] buf_q, buf_d;
    logic [INSTR_W-1:0] load_instr;
    logic               load_ifid;
    logic [31:0]        redirect_tgt;

    assign redirect_tgt = word_align(redirect_pc);
    assign imem.req     = !reset && (state_q != HOLD);
    assign imem.addr    = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        buf_d      = buf_q;
        load_instr = imem.rdata;
        load_ifid  = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    // An outstanding request cannot be withdrawn, so its answer is dropped later.
                    if (imem.ready) begin
                        pc_d = redirect_tgt;
                    end else begin
                        target_d = redirect_tgt;
                        state_d  = DROP;
                    end
                end else if (imem.ready) begin
                    if (stall) begin
                        buf_d   = imem.rdata;
                        state_d = HOLD;
                    end else begin
                        load_ifid = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    target_d = redirect_tgt;
                end
                if (imem.ready) begin
                    pc_d    = redirect ? redirect_tgt : target_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end else if (!stall) begin
                    load_ifid  = 1'b1;
                    load_instr = buf_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
        target_q <= target_d;
        buf_q    <= buf_d;
    end

    if_id_reg #(.NOP(NOP)) u_if_id (
        .clk        (Clock),
        .reset      (reset),
        .bubble_i   (redirect || flush),
        .hold_i     (stall),
        .load_i     (load_ifid),
        .instr_i    (load_instr),
        .pc_i       (pc_q),
        .instr_o    (instruction_1),
        .pc_o       (pc_1),
        .pc_plus4_o (pcPlus4_1),
        .valid_o    (valid_1)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, corner sequences and random traffic vs a reference model.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic        O   = 1'b0;
    localparam logic        I   = 1'b1;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    logic        Clock = 1'b0;
    logic        reset;
    logic        stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instruction_1, pc_1, pcPlus4_1;
    logic        valid_1;
    logic        tb_ready;

    fetch_stage_if bus();
    assign bus.ready = tb_ready;
    assign bus.rdata = tag(bus.addr);

    always #5 Clock = ~Clock;

    fetch_stage #(.RESET_PC(RPC), .NOP(NOP_INSTR)) dut (
        .Clock         (Clock),
        .reset         (reset),
        .imem          (bus),
        .stall         (stall),
        .flush         (flush),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instruction_1 (instruction_1),
        .pc_1          (pc_1),
        .pcPlus4_1     (pcPlus4_1),
        .valid_1       (valid_1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the next address to ask for, an abandoned request still in flight,
    // a word parked while decode is stalled, and what decode should be holding.
    logic [31:0] m_pc, m_tgt, m_park;
    logic        m_abandoned, m_parked;
    logic [31:0] e_instr, e_pc, e_p4;
    logic        e_vld;

    task automatic model_bubble();
        e_instr = NOP_INSTR; e_pc = '0; e_p4 = '0; e_vld = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = RPC; m_abandoned = 1'b0; m_parked = 1'b0;
        model_bubble();
    endtask

    task automatic model_edge(input logic r, rdy, s, f, rd, input logic [31:0] rpc);
        logic [31:0] t;
        logic        got;
        logic [31:0] word;
        if (r) begin
            model_reset();
            return;
        end
        t = rpc & 32'hFFFF_FFFC;
        got = 1'b0;
        word = '0;
        if (rd) begin
            if (m_parked) begin
                m_parked = 1'b0; m_pc = t;
            end else if (rdy) begin
                m_abandoned = 1'b0; m_pc = t;
            end else begin
                m_abandoned = 1'b1; m_tgt = t;
            end
        end else if (m_abandoned) begin
            if (rdy) begin m_abandoned = 1'b0; m_pc = m_tgt; end
        end else if (m_parked) begin
            if (!s) begin m_parked = 1'b0; got = 1'b1; word = m_park; end
        end else if (rdy) begin
            if (s) begin m_parked = 1'b1; m_park = tag(m_pc); end
            else begin got = 1'b1; word = tag(m_pc); end
        end
        if (rd || f) model_bubble();
        else if (s) ;
        else if (got) begin
            e_instr = word; e_pc = m_pc; e_p4 = m_pc + 32'd4; e_vld = 1'b1;
        end else model_bubble();
        if (got) m_pc = m_pc + 32'd4;
    endtask

    task automatic step(input logic r, rdy, s, f, rd, input logic [31:0] rpc,
                        output logic o_req, output logic [31:0] o_addr);
        reset = r; tb_ready = rdy; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
        #1;
        o_req  = bus.req;
        o_addr = bus.addr;
        check("model_req", 32'(bus.req), 32'(!r && !m_parked));
        check("model_addr", bus.addr, m_pc);
        @(posedge Clock);
        model_edge(r, rdy, s, f, rd, rpc);
        #1;
        check("model_instr", instruction_1, e_instr);
        check("model_pc1", pc_1, e_pc);
        check("model_pcp4", pcPlus4_1, e_p4);
        check("model_valid", 32'(valid_1), 32'(e_vld));
    endtask

    typedef struct {
        logic        r, rdy, s, f, rd;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc, ep4;
    } vec_t;
    vec_t tbl[$];

    task automatic v(input logic r, rdy, s, f, rd, input logic [31:0] rpc,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic evld, input logic [31:0] epc, ep4);
        vec_t x;
        x.r = r; x.rdy = rdy; x.s = s; x.f = f; x.rd = rd; x.rpc = rpc;
        x.ereq = ereq; x.eaddr = eaddr; x.evld = evld; x.epc = epc; x.ep4 = ep4;
        tbl.push_back(x);
    endtask

    initial begin
        logic        q;
        logic [31:0] a;
        reset = 1'b1; tb_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge Clock);
        #1;
        model_reset();
        check("rst_req", 32'(bus.req), 32'(O));
        check("rst_addr", bus.addr, RPC);
        check("rst_instr", instruction_1, NOP_INSTR);
        check("rst_pc1", pc_1, 32'h0);
        check("rst_pcp4", pcPlus4_1, 32'h0);
        check("rst_valid", 32'(valid_1), 32'(O));

        // r rdy s f rd rpc          | req addr          | valid pc_1 pcPlus4_1
        v(I, I, O, O, O, 32'h0,        O, 32'h0,         O, 32'h0, 32'h0);
        v(O, I, O, O, O, 32'h0,        I, 32'h0,         I, 32'h0, 32'h4);
        v(O, I, O, O, O, 32'h0,        I, 32'h4,         I, 32'h4, 32'h8);
        v(O, I, I, O, O, 32'h0,        I, 32'h8,         I, 32'h4, 32'h8);
        v(O, O, I, O, O, 32'h0,        O, 32'h8,         I, 32'h4, 32'h8);
        v(O, O, I, O, O, 32'h0,        O, 32'h8,         I, 32'h4, 32'h8);
        v(O, O, O, O, O, 32'h0,        O, 32'h8,         I, 32'h8, 32'hC);
        v(O, I, O, O, O, 32'h0,        I, 32'hC,         I, 32'hC, 32'h10);
        v(O, I, O, O, O, 32'h0,        I, 32'h10,        I, 32'h10, 32'h14);
        v(O, I, O, O, I, 32'h40,       I, 32'h14,        O, 32'h0, 32'h0);
        v(O, I, O, O, O, 32'h0,        I, 32'h40,        I, 32'h40, 32'h44);
        v(O, O, O, O, I, 32'h80,       I, 32'h44,        O, 32'h0, 32'h0);
        v(O, O, O, O, O, 32'h0,        I, 32'h44,        O, 32'h0, 32'h0);
        v(O, I, O, O, O, 32'h0,        I, 32'h44,        O, 32'h0, 32'h0);
        v(O, I, O, O, O, 32'h0,        I, 32'h80,        I, 32'h80, 32'h84);
        v(O, I, O, O, I, 32'hFFFF_FFFC, I, 32'h84,       O, 32'h0, 32'h0);
        v(O, I, O, O, O, 32'h0,        I, 32'hFFFF_FFFC, I, 32'hFFFF_FFFC, 32'h0);
        v(O, I, O, O, I, 32'h13,       I, 32'h0,         O, 32'h0, 32'h0);
        v(O, I, O, O, O, 32'h0,        I, 32'h10,        I, 32'h10, 32'h14);
        v(O, I, O, I, O, 32'h0,        I, 32'h14,        O, 32'h0, 32'h0);
        v(O, I, O, O, O, 32'h0,        I, 32'h18,        I, 32'h18, 32'h1C);
        v(O, O, O, O, I, 32'h100,      I, 32'h1C,        O, 32'h0, 32'h0);
        v(I, O, O, O, O, 32'h0,        O, 32'h1C,        O, 32'h0, 32'h0);
        v(O, I, O, O, O, 32'h0,        I, 32'h0,         I, 32'h0, 32'h4);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].rdy, tbl[i].s, tbl[i].f, tbl[i].rd, tbl[i].rpc, q, a);
            check($sformatf("vec%0d_req", i), 32'(q), 32'(tbl[i].ereq));
            check($sformatf("vec%0d_addr", i), a, tbl[i].eaddr);
            check($sformatf("vec%0d_valid", i), 32'(valid_1), 32'(tbl[i].evld));
            check($sformatf("vec%0d_pc1", i), pc_1, tbl[i].epc);
            check($sformatf("vec%0d_pcp4", i), pcPlus4_1, tbl[i].ep4);
            check($sformatf("vec%0d_instr", i), instruction_1,
                  tbl[i].evld ? tag(tbl[i].epc) : NOP_INSTR);
        end

        // Two redirects while a request is abandoned: the later target is fetched.
        step(O, O, O, O, I, 32'h200, q, a);
        step(O, O, O, O, I, 32'h300, q, a);
        step(O, I, O, O, O, 32'h0, q, a);
        check("last_target_addr", bus.addr, 32'h300);
        check("last_target_valid", 32'(valid_1), 32'(O));

        // Redirect while a word is parked discards it and requests the target next cycle.
        step(O, I, I, O, O, 32'h0, q, a);
        step(O, O, O, O, I, 32'h504, q, a);
        check("hold_redir_addr", bus.addr, 32'h504);
        check("hold_redir_req", 32'(bus.req), 32'(I));
        check("hold_redir_valid", 32'(valid_1), 32'(O));
        step(O, I, O, O, O, 32'h0, q, a);
        check("hold_redir_pc1", pc_1, 32'h504);

        for (int n = 0; n < 600; n++) begin
            step(logic'($urandom_range(0, 39) == 0),
                 logic'($urandom_range(0, 9) < 6),
                 logic'($urandom_range(0, 3) == 0),
                 logic'($urandom_range(0, 9) == 0),
                 logic'($urandom_range(0, 9) == 0),
                 $urandom, q, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
